// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_access_ctrl : data-memory handshake controller for the Memory stage
// Rev 1.0
// ============================================================================
module dmem_access_ctrl #(
  parameter int data_size = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [data_size-1:0] ALUOutM,
  input  logic [data_size-1:0] WriteDataM,
  input  logic                 mem_ack,
  input  logic [data_size-1:0] mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [data_size-1:0] mem_addr,
  output logic [data_size-1:0] mem_wdata,
  output logic [data_size-1:0] ReadDataM,
  output logic                 StallM,
  output logic                 ErrorM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       w_access;

  assign w_access = MemReadM | MemWriteM;

  // Hold the pipeline while a request is being launched or is outstanding.
  assign StallM = (r_state == BUSY) || ((r_state == IDLE) && w_access);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      ErrorM    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_state   <= BUSY;
            r_cnt     <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUOutM;
            mem_wdata <= WriteDataM;
          end
        end
        BUSY: begin
          // An ack arriving on the expiry cycle still counts as a completion.
          if (mem_ack) begin
            r_state <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              ReadDataM <= mem_rdata;
            end
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            ReadDataM <= '0;
            ErrorM    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_access_ctrl : directed bench with a transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_dmem_access_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, mem_ack;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic        mem_req, mem_we, StallM, ErrorM;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dmem_access_ctrl #(.data_size(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .ErrorM(ErrorM)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, its age, and a one-cycle
  // completion window during which new accesses are ignored.
  bit          m_pend, m_done, m_we, m_err;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= 0; m_done <= 0; m_we <= 0; m_err <= 0; m_waited <= 0;
      m_addr <= 0; m_wdata <= 0; m_rd <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_pend) begin
      if (mem_ack || (m_waited + 1 == TMO)) begin
        m_pend <= 0; m_we <= 0; m_done <= 1;
        if (mem_ack) begin
          if (!m_we) m_rd <= mem_rdata;
        end else begin
          m_rd <= 0; m_err <= 1;
        end
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (MemReadM || MemWriteM) begin
      m_pend <= 1; m_we <= MemWriteM; m_addr <= ALUOutM; m_wdata <= WriteDataM;
      m_waited <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mem_req",   mem_req,   m_pend);
      cmp("mem_we",    mem_we,    m_we);
      cmp("mem_addr",  mem_addr,  m_addr);
      cmp("mem_wdata", mem_wdata, m_wdata);
      cmp("ReadDataM", ReadDataM, m_rd);
      cmp("ErrorM",    ErrorM,    m_err);
      cmp("StallM",    StallM,    m_pend || (!m_done && (MemReadM || MemWriteM)));
    end
  end

  int rises = 0;
  logic r_prev = 1'b0;
  always @(posedge clk) begin
    r_prev <= mem_req;
    if (mem_req && !r_prev) rises <= rises + 1;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present one access and drive it to completion. ack_at = BUSY cycle on which
  // to ack (0 = never). Returns at DONE with access dropped.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd,
                           output int stalls, output int busy_n,
                           output int we_n, output int first_req);
    int n;
    bit done;
    n = 0; done = 0; stalls = 0; we_n = 0; first_req = -1;
    MemReadM = !wr; MemWriteM = wr; ALUOutM = addr; WriteDataM = wd; mem_rdata = rd;
    for (int i = 0; i < 64 && !done; i++) begin
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        if (first_req < 0) first_req = i;
        n++;
        if (StallM) stalls++;
        if (mem_we) we_n++;
        mem_ack = (n == ack_at);
      end else if (n > 0) begin
        done = 1;
      end else if (StallM) begin
        stalls++;
      end
      if (!done) cyc();
    end
    if (!done) cmp("access_completion", 32'd0, 32'd1);
    busy_n = n;
    mem_ack = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  int s, n, w, f, r0;

  initial begin
    reset = 1'b0; MemReadM = 0; MemWriteM = 0; mem_ack = 0;
    ALUOutM = 0; WriteDataM = 0; mem_rdata = 0;
    cyc(); cyc();
    chk_en = 1'b1;
    cmp("rst_mem_req", mem_req, 1'b0);
    cmp("rst_ReadDataM", ReadDataM, 32'h0);
    cmp("rst_ErrorM", ErrorM, 1'b0);
    cmp("rst_StallM", StallM, 1'b0);
    reset = 1'b1;
    cyc();

    // Load with immediate ack
    do_access(0, 32'h100, 32'h0, 1, 32'hDEADBEEF, s, n, w, f);
    cmp("load_stalls", s, 2);
    cmp("load_busy", n, 1);
    cmp("load_data", ReadDataM, 32'hDEADBEEF);
    cmp("load_err", ErrorM, 1'b0);
    repeat (2) cyc();

    // Store, ack on third BUSY cycle
    do_access(1, 32'h200, 32'h12345678, 3, 32'hFFFF0000, s, n, w, f);
    cmp("store_stalls", s, 4);
    cmp("store_we_cycles", w, 3);
    cmp("store_data_kept", ReadDataM, 32'hDEADBEEF);
    repeat (2) cyc();

    // Ack coincides with expiry
    do_access(0, 32'h300, 32'h0, TMO, 32'hA5A5A5A5, s, n, w, f);
    cmp("expiry_busy", n, TMO);
    cmp("expiry_data", ReadDataM, 32'hA5A5A5A5);
    cmp("expiry_err", ErrorM, 1'b0);
    cyc();

    // Back-to-back loads, access held through DONE
    r0 = rises;
    do_access(0, 32'h400, 32'h0, 1, 32'h11111111, s, n, w, f);
    cmp("b2b_first_data", ReadDataM, 32'h11111111);
    do_access(0, 32'h404, 32'h0, 1, 32'h22222222, s, n, w, f);
    cmp("b2b_second_req_lat", f, 2);
    cmp("b2b_second_data", ReadDataM, 32'h22222222);
    cmp("b2b_requests", rises - r0, 2);
    repeat (2) cyc();

    // Timeout
    do_access(0, 32'h500, 32'h0, 0, 32'h0BAD0BAD, s, n, w, f);
    cmp("tmo_req_cycles", n, TMO);
    cmp("tmo_stalls", s, TMO + 1);
    cmp("tmo_data", ReadDataM, 32'h0);
    cmp("tmo_err", ErrorM, 1'b1);
    repeat (2) cyc();

    // Good load after timeout; error stays sticky
    do_access(0, 32'h600, 32'h0, 2, 32'hCAFEF00D, s, n, w, f);
    cmp("post_tmo_data", ReadDataM, 32'hCAFEF00D);
    cmp("post_tmo_err", ErrorM, 1'b1);
    repeat (2) cyc();

    // Reset during BUSY
    MemReadM = 1'b1; ALUOutM = 32'h700;
    cyc(); cyc(); cyc();
    cmp("pre_rst_req", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    cmp("async_rst_req", mem_req, 1'b0);
    cmp("async_rst_addr", mem_addr, 32'h0);
    cmp("async_rst_data", ReadDataM, 32'h0);
    cmp("async_rst_err", ErrorM, 1'b0);
    cmp("async_rst_stall", StallM, 1'b1);
    MemReadM = 1'b0;
    cyc();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    mem_ack = 1'b0;
    cmp("stray_ack_req", mem_req, 1'b0);
    cmp("stray_ack_data", ReadDataM, 32'h0);
    cyc();

    // First request after reset issues on the first qualifying edge
    do_access(0, 32'h800, 32'h0, 1, 32'h5A5A1234, s, n, w, f);
    cmp("post_rst_first_req", f, 1);
    cmp("post_rst_data", ReadDataM, 32'h5A5A1234);
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
